// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with bounded burst lock that shares one UART transmit path
// among N_REQ byte producers, chaining frames back to back while work is pending.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             lock,
  input  logic [N_REQ*DATA_SIZE-1:0]   req_data,
  output logic [N_REQ-1:0]             ack,
  output logic [N_REQ-1:0]             grant,
  output logic                         tx_on,
  output logic [DATA_SIZE-1:0]         tx_data,
  input  logic                         tx_data_seen,
  input  logic                         tx_busy,
  output logic                         active,
  output logic                         err_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int BST_W = $clog2(MAX_BURST + 1);
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W:0]   N_REQ_X     = (IDX_W + 1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [BST_W-1:0] MAX_BURST_C = BST_W'(MAX_BURST);
  localparam logic [BST_W-1:0] BURST_ONE   = BST_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE     = TMO_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [IDX_W-1:0]       ptr_r;
  logic [IDX_W-1:0]       owner_r;
  logic                   owner_vld_r;
  logic [BST_W-1:0]       burst_r;
  logic [TMO_W-1:0]       tmo_r;
  logic [N_REQ-1:0]       ack_r;
  logic [N_REQ-1:0]       grant_r;
  logic                   tx_on_r;
  logic [DATA_SIZE-1:0]   tx_data_r;
  logic                   active_r;
  logic                   err_r;

  logic                   lock_hit_s;
  logic                   rr_vld_s;
  logic [IDX_W-1:0]       rr_idx_s;
  logic [IDX_W:0]         cand_s;
  logic [IDX_W-1:0]       cand_idx_s;
  logic                   sel_vld_s;
  logic [IDX_W-1:0]       sel_idx_s;
  logic [N_REQ-1:0]       sel_oh_s;
  logic [DATA_SIZE-1:0]   cap_data_s;
  logic [IDX_W-1:0]       nxt_ptr_s;
  logic [BST_W-1:0]       nxt_burst_s;

  // busy is informational only; sequencing relies on data_seen alone
  logic                   unused_busy_s;
  assign unused_busy_s = tx_busy;

  // Arbitration decision: burst continuation for a locking owner, else round-robin from ptr
  always_comb begin
    lock_hit_s = owner_vld_r & req[owner_r] & lock[owner_r] & (burst_r < MAX_BURST_C);
    rr_vld_s   = 1'b0;
    rr_idx_s   = {IDX_W{1'b0}};
    cand_s     = {(IDX_W + 1){1'b0}};
    cand_idx_s = {IDX_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      cand_s     = {1'b0, ptr_r} + (IDX_W + 1)'(k);
      cand_s     = (cand_s >= N_REQ_X) ? (cand_s - N_REQ_X) : cand_s;
      cand_idx_s = cand_s[IDX_W-1:0];
      rr_idx_s   = (req[cand_idx_s] & ~rr_vld_s) ? cand_idx_s : rr_idx_s;
      rr_vld_s   = rr_vld_s | req[cand_idx_s];
    end
    sel_vld_s   = lock_hit_s | rr_vld_s;
    sel_idx_s   = lock_hit_s ? owner_r : rr_idx_s;
    sel_oh_s    = {{(N_REQ - 1){1'b0}}, 1'b1} << sel_idx_s;
    cap_data_s  = req_data[int'(sel_idx_s) * DATA_SIZE +: DATA_SIZE];
    nxt_ptr_s   = (rr_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : (rr_idx_s + IDX_ONE);
    nxt_burst_s = lock_hit_s ? (burst_r + BURST_ONE) : BURST_ONE;
  end

  // Controller FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ptr_r       <= {IDX_W{1'b0}};
      owner_r     <= {IDX_W{1'b0}};
      owner_vld_r <= 1'b0;
      burst_r     <= {BST_W{1'b0}};
      tmo_r       <= {TMO_W{1'b0}};
      ack_r       <= {N_REQ{1'b0}};
      grant_r     <= {N_REQ{1'b0}};
      tx_on_r     <= 1'b0;
      tx_data_r   <= {DATA_SIZE{1'b0}};
      active_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      ack_r <= {N_REQ{1'b0}};
      err_r <= 1'b0;
      case (state_r)
        S_IDLE, S_HOLD: begin
          // HOLD waits out the start bit so the owner's req is resampled after its ack
          if ((state_r == S_HOLD) && tx_data_seen) begin
            state_r <= S_HOLD;
          end else if (sel_vld_s) begin
            state_r     <= S_OFFER;
            grant_r     <= sel_oh_s;
            tx_data_r   <= cap_data_s;
            tx_on_r     <= 1'b1;
            active_r    <= 1'b1;
            owner_r     <= sel_idx_s;
            owner_vld_r <= 1'b1;
            burst_r     <= nxt_burst_s;
            tmo_r       <= {TMO_W{1'b0}};
            if (lock_hit_s) begin
              ptr_r <= ptr_r;
            end else begin
              ptr_r <= nxt_ptr_s;
            end
          end else begin
            state_r     <= S_IDLE;
            grant_r     <= {N_REQ{1'b0}};
            tx_on_r     <= 1'b0;
            active_r    <= 1'b0;
            owner_vld_r <= 1'b0;
          end
        end
        S_OFFER: begin
          if (tx_data_seen) begin
            state_r <= S_HOLD;
            ack_r   <= grant_r;
          end else if (tmo_r == TMO_LAST) begin
            state_r     <= S_IDLE;
            err_r       <= 1'b1;
            grant_r     <= {N_REQ{1'b0}};
            tx_on_r     <= 1'b0;
            active_r    <= 1'b0;
            owner_vld_r <= 1'b0;
          end else begin
            tmo_r <= tmo_r + TMO_ONE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          grant_r     <= {N_REQ{1'b0}};
          tx_on_r     <= 1'b0;
          active_r    <= 1'b0;
          owner_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign ack         = ack_r;
  assign grant       = grant_r;
  assign tx_on       = tx_on_r;
  assign tx_data     = tx_data_r;
  assign active      = active_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus pushes expected frames,
// a monitor pops and compares on every ack pulse; a small UART model drives data_seen.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N_REQ     = 4;
  localparam int DATA_SIZE = 8;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 32;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [N_REQ-1:0]           req;
  logic [N_REQ-1:0]           lock;
  logic [N_REQ*DATA_SIZE-1:0] req_data;
  logic [N_REQ-1:0]           ack;
  logic [N_REQ-1:0]           grant;
  logic                       tx_on;
  logic [DATA_SIZE-1:0]       tx_data;
  logic                       tx_data_seen;
  logic                       tx_busy;
  logic                       active;
  logic                       err_timeout;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_cnt = 0;
  int          gap_cnt = 0;
  bit          watch_on = 1'b0;
  bit          uart_en  = 1'b1;
  logic [15:0] exp_q[$];

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .DATA_SIZE(DATA_SIZE), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .req_data(req_data),
    .ack(ack), .grant(grant), .tx_on(tx_on), .tx_data(tx_data),
    .tx_data_seen(tx_data_seen), .tx_busy(tx_busy),
    .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] frame_exp(input int idx, input logic [7:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    return {oh, oh, d};
  endfunction

  function automatic logic [31:0] outs();
    return {13'h0, ack, grant, tx_on, active, err_timeout, tx_data};
  endfunction

  // UART model: about 5 cycles after tx_on, data_seen high for 3 cycles, frame ends 4 later
  initial begin
    tx_data_seen = 1'b0;
    tx_busy      = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_en && tx_on) begin
        tx_busy = 1'b1;
        repeat (4) @(negedge clk);
        tx_data_seen = 1'b1;
        repeat (3) @(negedge clk);
        tx_data_seen = 1'b0;
        repeat (4) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every ack pulse pops one expected {ack, grant, tx_data}; ack must be one cycle wide
  initial begin
    logic        ack_prev;
    logic [15:0] e;
    ack_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (watch_on && !tx_on) gap_cnt++;
      if (ack !== 4'b0000) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: ack 0x%0h grant 0x%0h, expected no ack", ack, grant);
        end else begin
          e = exp_q.pop_front();
          check("sb_frame {ack_prev,ack,grant,tx_data}", {15'h0, ack_prev, ack, grant, tx_data},
                {15'h0, 1'b0, e});
        end
      end
      ack_prev = (ack !== 4'b0000);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    int n;
    @(negedge clk);
    rst  = 1'b1;
    req  = 4'b0000;
    lock = 4'b0000;
    #1 check("reset_outputs", outs(), 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy && n < 50);
    rst = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_cnt < target && n < budget);
    if (ack_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d acks after %0d cycles, expected %0d", name, ack_cnt, budget, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_on && n < 60);
    check(name, {22'h0, ack, grant, tx_on, active}, 32'h0);
  endtask

  initial begin
    int          base;
    int          cyc;
    int          fair_seq[6]   = '{0, 1, 3, 0, 1, 3};
    int          burst_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [7:0]  fd[4]         = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    rst = 1'b1; req = 4'b0000; lock = 4'b0000; req_data = 32'h0;

    // single requester
    do_reset();
    base = ack_cnt;
    req_data = 32'h00A5_0000;
    exp_q.push_back(frame_exp(2, 8'hA5));
    req = 4'b0100;
    @(posedge clk); #1;
    check("single_latency {tx_on,grant,active,tx_data}", {tx_on, grant, active, tx_data},
          {1'b1, 4'b0100, 1'b1, 8'hA5});
    wait_acks(base + 1, 40, "single_ack");
    req = 4'b0000;
    wait_idle("single_idle");

    // fairness, no lock
    do_reset();
    base = ack_cnt;
    gap_cnt = 0;
    req_data = {fd[3], fd[2], fd[1], fd[0]};
    for (int i = 0; i < 6; i++) exp_q.push_back(frame_exp(fair_seq[i], fd[fair_seq[i]]));
    req = 4'b1011;
    @(posedge clk); #1;
    watch_on = 1'b1;
    wait_acks(base + 6, 200, "fair_acks");
    watch_on = 1'b0;
    req = 4'b0000;
    check("fair_tx_on_gap_cycles", gap_cnt, 32'd0);
    wait_idle("fair_idle");
    check("fair_sb_drained", exp_q.size(), 32'd0);

    // burst lock
    do_reset();
    base = ack_cnt;
    req_data = {fd[3], fd[2], fd[1], fd[0]};
    for (int i = 0; i < 10; i++) exp_q.push_back(frame_exp(burst_seq[i], fd[burst_seq[i]]));
    lock = 4'b0001;
    req  = 4'b0011;
    wait_acks(base + 10, 300, "burst_acks");
    req  = 4'b0000;
    lock = 4'b0000;
    wait_idle("burst_idle");
    check("burst_sb_drained", exp_q.size(), 32'd0);

    // timeout with data_seen stuck low
    do_reset();
    base = ack_cnt;
    uart_en = 1'b0;
    req_data = 32'h0000_3C00;
    req = 4'b0010;
    @(posedge clk); #1;
    check("tmo_offer_entry {tx_on,grant}", {tx_on, grant}, {1'b1, 4'b0010});
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!err_timeout && cyc < 2 * TIMEOUT);
    check("tmo_cycles_to_err", cyc, TIMEOUT);
    check("tmo_outputs {tx_on,grant,active,err}", {tx_on, grant, active, err_timeout},
          {1'b0, 4'b0000, 1'b0, 1'b1});
    check("tmo_no_ack", ack_cnt, base);
    @(negedge clk);
    req_data = 32'h0000_5A00;
    uart_en  = 1'b1;
    exp_q.push_back(frame_exp(1, 8'h5A));
    @(posedge clk); #1;
    check("tmo_retry {err,tx_on,grant}", {err_timeout, tx_on, grant}, {1'b0, 1'b1, 4'b0010});
    wait_acks(base + 1, 60, "tmo_retry_ack");
    req = 4'b0000;
    wait_idle("tmo_idle");

    // data stability across OFFER and HOLD
    do_reset();
    base = ack_cnt;
    req_data = 32'h0000_0011;
    exp_q.push_back(frame_exp(0, 8'h11));
    req = 4'b0001;
    @(negedge clk);
    req_data = 32'h0000_00EE;
    @(posedge clk); #1;
    check("stab_offer tx_data", tx_data, 32'h11);
    wait_acks(base + 1, 40, "stab_ack");
    req_data = 32'h0000_0077;
    @(posedge clk); #1;
    check("stab_hold {tx_on,tx_data}", {tx_on, tx_data}, {1'b1, 8'h11});
    @(negedge clk);
    req = 4'b0000;
    wait_idle("stab_idle");

    // reset while data_seen is high
    do_reset();
    base = ack_cnt;
    req_data = 32'h9900_0000;
    req = 4'b1000;
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!tx_data_seen && cyc < 40);
    check("rst_seen_reached", tx_data_seen, 32'd1);
    rst = 1'b1;
    #1 check("rst_async_outputs", outs(), 32'h0);
    req = 4'b0100;
    req_data = 32'h0042_0000;
    repeat (3) @(posedge clk);
    #1 check("rst_no_ack", ack_cnt, base);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (tx_busy && cyc < 50);
    exp_q.push_back(frame_exp(2, 8'h42));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_regrant {tx_on,grant}", {tx_on, grant}, {1'b1, 4'b0100});
    wait_acks(base + 1, 40, "rst_regrant_ack");
    req = 4'b0000;
    wait_idle("rst_idle");
    check("final_sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit path (controller FSM plus shift datapath) among N_REQ byte producers.
- Arbitrates round-robin, with an optional bounded burst lock per requester.
- Drives tx_on/tx_data into the UART and uses its data_seen handshake to acknowledge the granted producer.
- Keeps tx_on high across consecutive frames so the UART chains stop into start with no idle gap.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_SIZE, 8, frame data width; matches the UART data_size.
- MAX_BURST, 4, max consecutive frames granted to a locking requester (≥1).
- TIMEOUT, 256, OFFER-state cycles to wait for tx_data_seen; must be ≥ (DATA_SIZE+3)*NO_OF_CLKS of the UART.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req  in  N_REQ  per-requester frame request, level.
- lock  in  N_REQ  per-requester burst hint; sampled with req.
- req_data  in  N_REQ*DATA_SIZE  requester i data at bits [i*DATA_SIZE +: DATA_SIZE].
- ack  out  N_REQ  one-cycle pulse: the granted frame was latched by the UART.
- grant  out  N_REQ  one-hot current owner; 0 when none.
- tx_on  out  1  to UART Tx_on.
- tx_data  out  DATA_SIZE  to UART data input.
- tx_data_seen  in  1  from UART data_seen; high for the whole start-bit period.
- tx_busy  in  1  from UART busy; status only.
- active  out  1  arbiter not in IDLE.
- err_timeout  out  1  one-cycle pulse on OFFER timeout.

Behaviour:
- All outputs registered. Reset values: ack=0, grant=0, tx_on=0, tx_data=0, active=0, err_timeout=0, rr pointer=0, burst count=0, timeout count=0, state=IDLE.
- States: IDLE, OFFER, HOLD.
- Arbitration decision:
  - Eligible = req.
  - If the previous owner g has req[g]&lock[g] and burst count < MAX_BURST: pick g and increment burst count.
  - Otherwise pick the first set bit of req searching from the pointer upward, wrapping. Set pointer=(winner+1) mod N_REQ and burst count=1.
- IDLE:
  - With req≠0, the next cycle enters OFFER with grant=winner, tx_data=captured req_data[winner], tx_on=1, active=1.
  - Latency from req to tx_on is 1 cycle.
- OFFER:
  - tx_on=1; tx_data held from the capture. The requester may change req_data or drop req after grant with no effect.
  - When tx_data_seen=1, enter HOLD and set ack[owner]=1 for exactly one cycle (the first HOLD cycle).
  - When the timeout counter reaches TIMEOUT-1 without tx_data_seen: pulse err_timeout, go to IDLE with tx_on=0, grant=0, no ack. The pointer has already advanced past the owner.
- HOLD:
  - tx_on=1.
  - On the first cycle with tx_data_seen=0, run arbitration. The owner's req is sampled here, at least 1 cycle after its ack, so a requester that drops req on ack is not regranted.
  - Winner found: go directly to OFFER with the new capture; tx_on stays 1 for back-to-back frames.
  - No winner: go to IDLE with tx_on=0, grant=0, active=0.
- The timeout counter clears on entry to OFFER and saturates at TIMEOUT-1.
- tx_busy is not used for sequencing.
- Simultaneous requests: only one grant per decision. A requester set during HOLD competes at HOLD exit.
- If tx_data_seen is already 1 on OFFER entry, move to HOLD the next cycle. Only one ack per data_seen high period.
- Reset asserted mid-frame: immediate return to reset values. The in-flight frame is unacknowledged and the requester must retry.

Test Plan:
- Single requester: req[2]=1 with data 0xA5, UART model pulses data_seen after 5 cycles → tx_on rises 1 cycle after req, tx_data=0xA5, ack[2] one cycle on the first HOLD cycle; with req dropped, tx_on=0 after data_seen falls.
- Fairness: req=4'b1011 held with lock=0 for 6 frames → grant order 0,1,3,0,1,3; tx_on continuously 1 between frames.
- Burst lock: req=4'b0011, lock[0]=1, MAX_BURST=4 → grant sequence 0,0,0,0,1,0,0,0,0,1.
- Timeout: req[1]=1 with data_seen tied 0 → err_timeout pulse exactly TIMEOUT cycles after OFFER entry, tx_on=0, grant=0, ack never asserted; the next request from req[1] alone is served normally.
- Data stability: the requester changes req_data during OFFER → tx_data keeps the captured value until HOLD exit.
- Reset mid-HOLD: assert rst during data_seen high → all outputs 0 asynchronously, no ack; after release with req=4'b0100, grant goes to 2 with the pointer restarted at 0.
